// File: rtl/rect_addr_arb.sv
// Packet-granular round-robin arbiter. It merges N_SRC rect address streams onto one
// integral-image read port. A granted source keeps the port until its eot beat is
// accepted. A single output register gives 1-cycle latency and full throughput.
module rect_addr_arb #(
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned W_ADDR = 10,
    localparam int unsigned W_ID  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        src_valid_i,
    output logic [N_SRC-1:0]        src_ready_o,
    input  logic [N_SRC*W_ADDR-1:0] src_data_i,
    input  logic [N_SRC-1:0]        src_eot_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [W_ADDR-1:0]       out_data_o,
    output logic                    out_eot_o,
    output logic [W_ID-1:0]         out_id_o,
    output logic                    busy_o
);

    typedef enum logic {StIdle, StLock} state_e;

    state_e            state_q, state_d;
    logic [W_ID-1:0]   gnt_q, gnt_d;
    logic [W_ID-1:0]   rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [W_ADDR-1:0] out_data_q, out_data_d;
    logic              out_eot_q, out_eot_d;
    logic [W_ID-1:0]   out_id_q, out_id_d;

    logic              ld;
    logic              any_valid;
    logic [W_ID-1:0]   scan_idx;
    int unsigned       scan_pos;
    logic [W_ID-1:0]   sel_idx;
    logic              sel_vld;
    logic              sel_eot;
    logic [W_ADDR-1:0] sel_data;
    logic              grant_ok;
    logic              acc;
    logic [W_ID-1:0]   sel_next;

    assign ld = !out_valid_q || out_ready_i;

    // Round-robin scan: first valid source at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        any_valid = 1'b0;
        scan_idx  = rr_ptr_q;
        scan_pos  = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            scan_pos = (32'(rr_ptr_q) + k) % N_SRC;
            if (!any_valid && src_valid_i[W_ID'(scan_pos)]) begin
                any_valid = 1'b1;
                scan_idx  = W_ID'(scan_pos);
            end
        end
    end

    // Pick the serving source and mux its beat; a held grant bypasses the scan.
    always_comb begin
        sel_idx  = (state_q == StLock) ? gnt_q : scan_idx;
        sel_vld  = 1'b0;
        sel_eot  = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (W_ID'(i) == sel_idx) begin
                sel_vld  = src_valid_i[i];
                sel_eot  = src_eot_i[i];
                sel_data = src_data_i[i*W_ADDR +: W_ADDR];
            end
        end
        // In LOCK the granted source sees ready even across its own valid gaps.
        grant_ok = ld && !rst && ((state_q == StLock) || any_valid);
        acc      = grant_ok && sel_vld;
        sel_next = (sel_idx == W_ID'(N_SRC - 1)) ? '0 : sel_idx + W_ID'(1);
    end

    // One-hot ready towards the serving source only.
    always_comb begin
        src_ready_o = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            src_ready_o[i] = grant_ok && (W_ID'(i) == sel_idx);
        end
    end

    // Grant FSM next state: lock on a non-eot beat, release and advance pointer on eot.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        if (acc) begin
            if (sel_eot) begin
                state_d  = StIdle;
                rr_ptr_d = sel_next;
            end else if (state_q == StIdle) begin
                state_d = StLock;
                gnt_d   = sel_idx;
            end
        end
    end

    // Output register next state: load on acceptance, drain when free, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eot_d   = out_eot_q;
        out_id_d    = out_id_q;
        if (ld) begin
            out_valid_d = acc;
            if (acc) begin
                out_data_d = sel_data;
                out_eot_d  = sel_eot;
                out_id_d   = sel_idx;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eot_q   <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eot_q   <= out_eot_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_eot_o   = out_eot_q;
    assign out_id_o    = out_id_q;
    assign busy_o      = (state_q == StLock);

endmodule

// File: tb/tb_rect_addr_arb.sv
// Bench for rect_addr_arb: directed packet scenarios plus randomized traffic, all
// compared against a transaction-level model of the arbitration rules.
module tb_rect_addr_arb;

    localparam int N  = 3;
    localparam int W  = 10;
    localparam int WI = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_valid, src_ready, src_eot;
    logic [N*W-1:0] src_data;
    logic         out_valid, out_ready, out_eot, busy;
    logic [W-1:0] out_data;
    logic [WI-1:0] out_id;

    rect_addr_arb #(.N_SRC(N), .W_ADDR(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .src_data_i  (src_data),
        .src_eot_i   (src_eot),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_eot_o   (out_eot),
        .out_id_o    (out_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source drivers: remaining beats of the current packet and next address per source.
    int       beats_left[N];
    logic [W-1:0] addr[N];
    bit       gap[N];
    bit       respawn[N];
    bit       rnd_mode = 1'b0;
    int       vprob    = 100;
    bit       rst_req  = 1'b1;
    bit       ordy_req = 1'b1;

    // Reference model: locked source (-1 = none), round-robin pointer, output slot.
    int       m_lock = -1;
    int       m_ptr  = 0;
    bit       m_ov   = 1'b0;
    bit       m_oe   = 1'b0;
    logic [W-1:0] m_od = '0;
    int       m_oid  = 0;

    int obs_id[$];
    int exp_q[$];

    task automatic start_pkt(input int s, input int len);
        beats_left[s] = len;
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rdy;
        bit ld, acc;
        int cand;
        @(negedge clk);
        rst       = rst_req;
        out_ready = rnd_mode ? ($urandom_range(99) < 70) : ordy_req;
        for (int i = 0; i < N; i++) begin
            src_valid[i]      = (beats_left[i] > 0) && !gap[i] && ($urandom_range(99) < vprob);
            src_eot[i]        = (beats_left[i] == 1);
            src_data[i*W +: W] = addr[i];
        end
        #1;
        ld      = !m_ov || out_ready;
        cand    = -1;
        exp_rdy = '0;
        if (!rst) begin
            if (m_lock >= 0) cand = m_lock;
            else begin
                for (int k = 0; k < N; k++)
                    if (cand < 0 && src_valid[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
            end
            if (cand >= 0 && ld) exp_rdy[cand] = 1'b1;
        end
        acc = (cand >= 0) && ld && src_valid[cand];

        check_eq("src_ready", 32'(src_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(m_ov));
        check_eq("busy", 32'(busy), 32'(m_lock >= 0));
        if (m_ov) begin
            check_eq("out_data", 32'(out_data), 32'(m_od));
            check_eq("out_eot", 32'(out_eot), 32'(m_oe));
            check_eq("out_id", 32'(out_id), 32'(m_oid));
        end
        if (out_valid === 1'b1 && out_ready) obs_id.push_back(int'(out_id));

        if (rst) begin
            m_lock = -1; m_ptr = 0; m_ov = 1'b0; m_oe = 1'b0; m_od = '0; m_oid = 0;
            for (int i = 0; i < N; i++) beats_left[i] = 0;
        end else begin
            if (ld) begin
                m_ov = acc;
                if (acc) begin
                    m_od = addr[cand]; m_oe = src_eot[cand]; m_oid = cand;
                end
            end
            if (acc) begin
                if (src_eot[cand]) begin
                    m_lock = -1;
                    m_ptr  = (cand + 1) % N;
                end else begin
                    m_lock = cand;
                end
                beats_left[cand]--;
                addr[cand]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (beats_left[i] == 0 && respawn[i]) beats_left[i] = 1;
            if (beats_left[i] == 0 && rnd_mode && $urandom_range(7) == 0)
                beats_left[i] = $urandom_range(4, 1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
        obs_id.delete();
    endtask

    task automatic check_order(input string tag);
        check_eq({tag, "_cnt"}, 32'(obs_id.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs_id.size())
                check_eq($sformatf("%s_id%0d", tag, k), 32'(obs_id[k]), 32'(exp_q[k]));
        end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; src_valid = '0; src_eot = '0; src_data = '0;
        for (int i = 0; i < N; i++) begin
            beats_left[i] = 0; addr[i] = W'(i * 'h40); gap[i] = 1'b0; respawn[i] = 1'b0;
        end

        // Reset values of the output register.
        do_reset();
        check_eq("rst_data", 32'(out_data), 32'h0);
        check_eq("rst_id", 32'(out_id), 32'h0);
        check_eq("rst_eot", 32'(out_eot), 32'h0);

        // Three simultaneous 4-beat packets are served whole, in source order.
        start_pkt(0, 4); start_pkt(1, 4); start_pkt(2, 4);
        run(16);
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        check_order("three_pkts");

        // After src0 is served, src2 wins over src0.
        do_reset();
        start_pkt(0, 2);
        run(4);
        obs_id.delete();
        start_pkt(0, 1); start_pkt(2, 1);
        run(5);
        exp_q = '{2, 0};
        check_order("rr_skip");

        // Valid gaps on the locked source do not release the grant.
        do_reset();
        start_pkt(1, 4);
        run(2);
        gap[1] = 1'b1;
        start_pkt(0, 1);
        run(3);
        check_eq("gap_busy", 32'(busy), 32'h1);
        gap[1] = 1'b0;
        run(8);
        exp_q = '{1, 1, 1, 1, 0};
        check_order("gap_lock");

        // Downstream stall holds the output register and blocks every source.
        do_reset();
        addr[0] = W'('h123);
        start_pkt(0, 2);
        cycle();
        ordy_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("stall_data", 32'(out_data), 32'h123);
            check_eq("stall_rdy", 32'(src_ready), 32'h0);
        end
        ordy_req = 1'b1;
        run(2);
        check_eq("resume_data", 32'(out_data), 32'h124);

        // Reset mid-packet drops lock and output; arbitration restarts at source 0.
        do_reset();
        start_pkt(1, 4);
        run(2);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        check_eq("midrst_ov", 32'(out_valid), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        obs_id.delete();
        start_pkt(1, 1); start_pkt(0, 1);
        run(6);
        exp_q = '{0, 1};
        check_order("midrst_order");

        // Back-to-back 1-beat packets on src2 and src0 alternate.
        do_reset();
        start_pkt(1, 1);
        run(3);
        obs_id.delete();
        respawn[0] = 1'b1; respawn[2] = 1'b1;
        run(8);
        respawn[0] = 1'b0; respawn[2] = 1'b0;
        exp_q = '{2, 0, 2, 0, 2, 0};
        for (int k = 0; k < 6; k++)
            if (k < obs_id.size())
                check_eq($sformatf("alt_id%0d", k), 32'(obs_id[k]), 32'(exp_q[k]));
        check_eq("alt_cnt_ok", 32'(obs_id.size() >= 6), 32'h1);

        // Randomized traffic, stalls and occasional resets against the model.
        do_reset();
        rnd_mode = 1'b1;
        vprob    = 70;
        for (int c = 0; c < 3000; c++) begin
            rst_req = ($urandom_range(199) == 0);
            cycle();
        end
        rnd_mode = 1'b0;
        rst_req  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
